// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the register file with pending-write scoreboard.
package regfile_scoreboard_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int NUM_REGS       = 32;
  localparam int CNT_W          = 6;

  localparam logic [DEFAULT_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Number of set bits in a scoreboard vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = 6'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sum = sum + {5'd0, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register file: read ports, write port, issue and stall.
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic              ReadUse1;
  logic              ReadUse2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              Issue;
  logic [ADDR_W-1:0] IssueRegister;
  logic              Stall;
  logic [CNT_W-1:0]  PendingCount;

  // Pipeline side: decode and writeback stages.
  modport master (
    output ReadRegister1, ReadRegister2, ReadUse1, ReadUse2,
    output RegWrite, WriteRegister, WriteData, Issue, IssueRegister,
    input  ReadData1, ReadData2, Stall, PendingCount
  );

  // Register file side.
  modport slave (
    input  ReadRegister1, ReadRegister2, ReadUse1, ReadUse2,
    input  RegWrite, WriteRegister, WriteData, Issue, IssueRegister,
    output ReadData1, ReadData2, Stall, PendingCount
  );
endinterface

// File: rtl/regfile_scoreboard_bits.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
module regfile_scoreboard_bits
  import regfile_scoreboard_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_en,
  input  logic [DEFAULT_ADDR_W-1:0] set_idx,
  input  logic                      clr_en,
  input  logic [DEFAULT_ADDR_W-1:0] clr_idx,
  output logic [NUM_REGS-1:0]       pending,
  output logic [CNT_W-1:0]          pending_count
);

  logic [NUM_REGS-1:0] pending_d, pending_q;
  logic [CNT_W-1:0]    count_d, count_q;

  // Next pending vector: clear first, then set, so a new producer supersedes a landing writeback.
  always_comb begin
    pending_d = pending_q;
    if (clr_en && (clr_idx != REG_ZERO)) begin
      pending_d[clr_idx] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (set_en && (set_idx != REG_ZERO)) begin
      pending_d[set_idx] = 1'b1;
    end else begin
      pending_d[set_idx] = pending_d[set_idx];
    end
    pending_d[0] = 1'b0;
    count_d      = popcount(pending_d);
  end

  // Scoreboard bits and their registered population count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      count_q   <= 6'd0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending       = pending_q;
  assign pending_count = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// 32-entry MIPS register file with write-through bypass and pending-write stall logic.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
)(
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic                wr_live_s;
  logic [NREGS-1:0]    pending_s;
  logic [NREGS-1:0]    eff_s;
  logic                stall_s;
  logic                set_en_s;
  logic [DATA_W-1:0]   rd1_s, rd2_s;

  assign wr_live_s = bus.RegWrite && (bus.WriteRegister != REG_ZERO);

  // Next register contents: only the addressed nonzero register takes the writeback data.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = (wr_live_s && (bus.WriteRegister == ADDR_W'(i))) ? bus.WriteData : regs_q[i];
    end
    regs_d[0] = '0;
  end

  // Register storage, cleared immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports with same-cycle writeback bypass; forced to zero while reset is held.
  always_comb begin
    if (reset) begin
      rd1_s = '0;
      rd2_s = '0;
    end else begin
      rd1_s = (wr_live_s && (bus.WriteRegister == bus.ReadRegister1)) ? bus.WriteData
                                                                      : regs_q[bus.ReadRegister1];
      rd2_s = (wr_live_s && (bus.WriteRegister == bus.ReadRegister2)) ? bus.WriteData
                                                                      : regs_q[bus.ReadRegister2];
    end
  end

  // Effective hazards: a register whose writeback lands this cycle is covered by the bypass.
  always_comb begin
    eff_s = pending_s;
    if (wr_live_s) begin
      eff_s[bus.WriteRegister] = 1'b0;
    end else begin
      eff_s = pending_s;
    end
  end

  // RAW hazards on either used source, or WAW hold on the issuing destination.
  assign stall_s  = (bus.ReadUse1 && eff_s[bus.ReadRegister1]) ||
                    (bus.ReadUse2 && eff_s[bus.ReadRegister2]) ||
                    (bus.Issue    && eff_s[bus.IssueRegister]);
  assign set_en_s = bus.Issue && !stall_s;

  regfile_scoreboard_bits u_bits (
    .clk           (clk),
    .rst           (reset),
    .set_en        (set_en_s),
    .set_idx       (bus.IssueRegister),
    .clr_en        (wr_live_s),
    .clr_idx       (bus.WriteRegister),
    .pending       (pending_s),
    .pending_count (bus.PendingCount)
  );

  assign bus.ReadData1 = rd1_s;
  assign bus.ReadData2 = rd2_s;
  assign bus.Stall     = stall_s;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized traffic
// checked against an array/bitmask reference model.
module tb_regfile_scoreboard;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model --------------------------------------------------------
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pend = 32'd0;
  endtask

  function automatic logic m_hazard(input logic [4:0] n);
    logic landing;
    landing = bus.RegWrite && (bus.WriteRegister == n);
    return (n != 5'd0) && m_pend[n] && !landing;
  endfunction

  function automatic logic m_stall();
    return (bus.ReadUse1 && m_hazard(bus.ReadRegister1)) ||
           (bus.ReadUse2 && m_hazard(bus.ReadRegister2)) ||
           (bus.Issue    && m_hazard(bus.IssueRegister));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] n);
    if (n == 5'd0) return 32'd0;
    if (bus.RegWrite && bus.WriteRegister == n) return bus.WriteData;
    return m_regs[n];
  endfunction

  // Advance one clock edge, updating the model with what the DUT saw.
  task automatic tick();
    logic s;
    s = m_stall();
    @(posedge clk);
    if (bus.RegWrite && bus.WriteRegister != 5'd0) begin
      m_regs[bus.WriteRegister] = bus.WriteData;
      m_pend[bus.WriteRegister] = 1'b0;
    end
    if (bus.Issue && !s && bus.IssueRegister != 5'd0) m_pend[bus.IssueRegister] = 1'b1;
    #1;
  endtask

  task automatic idle();
    bus.ReadRegister1 = 5'd0; bus.ReadRegister2 = 5'd0;
    bus.ReadUse1 = 1'b0; bus.ReadUse2 = 1'b0;
    bus.RegWrite = 1'b0; bus.WriteRegister = 5'd0; bus.WriteData = 32'd0;
    bus.Issue = 1'b0; bus.IssueRegister = 5'd0;
  endtask

  // Scenarios --------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_reset();
    #2;
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", bus.Stall); end
    checks++; if (bus.PendingCount !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.PendingCount); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int r = 0; r < 32; r++) begin
      bus.ReadRegister1 = 5'(r);
      bus.ReadRegister2 = 5'(31 - r);
      #1;
      checks++; if (bus.ReadData1 !== 32'd0) begin errors++; $display("FAIL reset_rd1[%0d]: got %0h expected 0", r, bus.ReadData1); end
      checks++; if (bus.ReadData2 !== 32'd0) begin errors++; $display("FAIL reset_rd2[%0d]: got %0h expected 0", 31 - r, bus.ReadData2); end
    end
    checks++; if (bus.PendingCount !== 6'd0) begin errors++; $display("FAIL post_reset_count: got %0d expected 0", bus.PendingCount); end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd8; bus.WriteData = 32'hDEADBEEF;
    bus.ReadRegister1 = 5'd8;
    #1;
    checks++; if (bus.ReadData1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rd1: got %0h expected deadbeef", bus.ReadData1); end
    tick();
    bus.RegWrite = 1'b0; bus.WriteData = 32'd0;
    #1;
    checks++; if (bus.ReadData1 !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_rd1: got %0h expected deadbeef", bus.ReadData1); end
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd0; bus.WriteData = 32'h1234;
    bus.ReadRegister1 = 5'd0; bus.ReadRegister2 = 5'd0;
    #1;
    checks++; if (bus.ReadData1 !== 32'd0) begin errors++; $display("FAIL r0_bypass: got %0h expected 0", bus.ReadData1); end
    tick();
    bus.RegWrite = 1'b0;
    #1;
    checks++; if (bus.ReadData2 !== 32'd0) begin errors++; $display("FAIL r0_stored: got %0h expected 0", bus.ReadData2); end
    idle();
  endtask

  task automatic test_raw_stall();
    idle();
    bus.Issue = 1'b1; bus.IssueRegister = 5'd9;
    #1;
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL issue9_stall: got %0b expected 0", bus.Stall); end
    tick();
    bus.Issue = 1'b0; bus.ReadRegister2 = 5'd9; bus.ReadUse2 = 1'b1;
    #1;
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL raw9_stall: got %0b expected 1", bus.Stall); end
    checks++; if (bus.PendingCount !== 6'd1) begin errors++; $display("FAIL raw9_count: got %0d expected 1", bus.PendingCount); end
    tick();
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd9; bus.WriteData = 32'h55;
    #1;
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL wb9_stall: got %0b expected 0", bus.Stall); end
    checks++; if (bus.ReadData2 !== 32'h55) begin errors++; $display("FAIL wb9_rd2: got %0h expected 55", bus.ReadData2); end
    checks++; if (bus.PendingCount !== 6'd1) begin errors++; $display("FAIL wb9_count: got %0d expected 1", bus.PendingCount); end
    tick();
    idle();
    #1;
    checks++; if (bus.PendingCount !== 6'd0) begin errors++; $display("FAIL after_wb9_count: got %0d expected 0", bus.PendingCount); end
  endtask

  task automatic test_issue_hold();
    idle();
    bus.Issue = 1'b1; bus.IssueRegister = 5'd10;
    tick();
    #1;
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL waw10_stall: got %0b expected 1", bus.Stall); end
    tick();
    idle();
    #1;
    checks++; if (bus.PendingCount !== 6'd1) begin errors++; $display("FAIL waw10_count: got %0d expected 1", bus.PendingCount); end
    bus.ReadRegister1 = 5'd10; bus.ReadUse1 = 1'b1;
    bus.Issue = 1'b1; bus.IssueRegister = 5'd11;
    #1;
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL rs_hold_stall: got %0b expected 1", bus.Stall); end
    tick();
    idle();
    bus.ReadRegister2 = 5'd11; bus.ReadUse2 = 1'b1;
    #1;
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL r11_not_set: got %0b expected 0", bus.Stall); end
    checks++; if (bus.PendingCount !== 6'd1) begin errors++; $display("FAIL r11_count: got %0d expected 1", bus.PendingCount); end
    idle();
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd10; bus.WriteData = 32'hA10;
    tick();
    idle();
  endtask

  task automatic test_set_wins();
    idle();
    bus.Issue = 1'b1; bus.IssueRegister = 5'd12;
    tick();
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd12; bus.WriteData = 32'hC0C0;
    #1;
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL setwin_stall: got %0b expected 0", bus.Stall); end
    tick();
    idle();
    bus.ReadRegister1 = 5'd12; bus.ReadUse1 = 1'b1;
    #1;
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL setwin_pending: got %0b expected 1", bus.Stall); end
    checks++; if (bus.PendingCount !== 6'd1) begin errors++; $display("FAIL setwin_count: got %0d expected 1", bus.PendingCount); end
    checks++; if (bus.ReadData1 !== 32'hC0C0) begin errors++; $display("FAIL setwin_data: got %0h expected c0c0", bus.ReadData1); end
    idle();
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd12; bus.WriteData = 32'hC1C1;
    tick();
    idle();
  endtask

  task automatic test_unused_and_zero();
    idle();
    bus.Issue = 1'b1; bus.IssueRegister = 5'd5;
    tick();
    idle();
    bus.ReadRegister1 = 5'd5; bus.ReadUse1 = 1'b0;
    #1;
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL unused_rs: got %0b expected 0", bus.Stall); end
    bus.ReadUse1 = 1'b1;
    #1;
    checks++; if (bus.Stall !== 1'b1) begin errors++; $display("FAIL used_rs: got %0b expected 1", bus.Stall); end
    idle();
    bus.Issue = 1'b1; bus.IssueRegister = 5'd0;
    #1;
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL issue0_stall: got %0b expected 0", bus.Stall); end
    tick();
    idle();
    bus.ReadRegister2 = 5'd0; bus.ReadUse2 = 1'b1;
    #1;
    checks++; if (bus.PendingCount !== 6'd1) begin errors++; $display("FAIL issue0_count: got %0d expected 1", bus.PendingCount); end
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL r0_hazard: got %0b expected 0", bus.Stall); end
    idle();
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd5; bus.WriteData = 32'h5;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd3; bus.WriteData = 32'hA5A5A5A5;
    bus.Issue = 1'b1; bus.IssueRegister = 5'd2;
    tick();
    idle();
    bus.Issue = 1'b1; bus.IssueRegister = 5'd8;
    tick();
    idle();
    #1;
    checks++; if (bus.PendingCount !== 6'd2) begin errors++; $display("FAIL pre_reset_count: got %0d expected 2", bus.PendingCount); end
    bus.ReadRegister1 = 5'd3;
    bus.ReadRegister2 = 5'd2; bus.ReadUse2 = 1'b1;
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd3; bus.WriteData = 32'hFFFF0000;
    rst = 1'b1;
    #1;
    model_reset();
    checks++; if (bus.ReadData1 !== 32'd0) begin errors++; $display("FAIL midrst_rd1: got %0h expected 0", bus.ReadData1); end
    checks++; if (bus.ReadData2 !== 32'd0) begin errors++; $display("FAIL midrst_rd2: got %0h expected 0", bus.ReadData2); end
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %0b expected 0", bus.Stall); end
    checks++; if (bus.PendingCount !== 6'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", bus.PendingCount); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ReadRegister2 = 5'd8;
    #1;
    checks++; if (bus.ReadData1 !== 32'd0) begin errors++; $display("FAIL no_write_in_reset: got %0h expected 0", bus.ReadData1); end
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("FAIL pending8_dropped: got %0b expected 0", bus.Stall); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.ReadRegister1 = 5'($urandom_range(0, 7));
      bus.ReadRegister2 = 5'($urandom_range(0, 7));
      bus.ReadUse1      = 1'($urandom_range(0, 1));
      bus.ReadUse2      = 1'($urandom_range(0, 1));
      bus.RegWrite      = ($urandom_range(0, 2) == 0);
      bus.WriteRegister = 5'($urandom_range(0, 7));
      bus.WriteData     = $urandom;
      bus.Issue         = ($urandom_range(0, 2) == 0);
      bus.IssueRegister = 5'($urandom_range(0, 7));
      #1;
      checks++; if (bus.Stall !== m_stall()) begin errors++; $display("FAIL rnd_stall[%0d]: got %0b expected %0b", c, bus.Stall, m_stall()); end
      checks++; if (bus.ReadData1 !== m_read(bus.ReadRegister1)) begin errors++; $display("FAIL rnd_rd1[%0d]: got %0h expected %0h", c, bus.ReadData1, m_read(bus.ReadRegister1)); end
      checks++; if (bus.ReadData2 !== m_read(bus.ReadRegister2)) begin errors++; $display("FAIL rnd_rd2[%0d]: got %0h expected %0h", c, bus.ReadData2, m_read(bus.ReadRegister2)); end
      checks++; if (bus.PendingCount !== 6'($countones(m_pend))) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, bus.PendingCount, $countones(m_pend)); end
      tick();
    end
    idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_bypass();
    test_raw_stall();
    test_issue_hold();
    test_set_wins();
    test_unused_and_zero();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 32-entry MIPS register file. It is the consumer of the destination index produced by the RegDst write-register select, and also provides the two operand read ports.
- A per-register pending-write scoreboard tracks multi-cycle producers (loads, mult/div). It raises Stall when a source operand or the destination is still outstanding.
- Sits between decode (read ports, issue) and writeback (write port).

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (2**ADDR_W registers)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ReadRegister1  input  ADDR_W  rs index
- ReadRegister2  input  ADDR_W  rt index
- ReadUse1  input  1  instruction in decode consumes port 1
- ReadUse2  input  1  instruction in decode consumes port 2
- ReadData1  output  DATA_W  rs data
- ReadData2  output  DATA_W  rt data
- RegWrite  input  1  writeback enable
- WriteRegister  input  ADDR_W  writeback destination index
- WriteData  input  DATA_W  writeback data
- Issue  input  1  decode issues a multi-cycle producer
- IssueRegister  input  ADDR_W  destination of the issuing producer
- Stall  output  1  decode must hold
- PendingCount  output  6  number of set scoreboard bits (0..31)

Behaviour:
- Reset (asynchronous, active-high):
  - all registers clear to 0 immediately; pending[31:0] clears to 0.
  - ReadData1/2 read 0, Stall=0, PendingCount=0 while reset is high.
  - Reset mid-operation discards all pending bits; no writes occur while reset is high.
- Register 0:
  - never written and never marked pending; reads always return 0.
  - Issue or RegWrite targeting index 0 is ignored.
- Write:
  - at posedge clk, if RegWrite and WriteRegister!=0, then reg[WriteRegister] <= WriteData.
- Read:
  - combinational, zero latency.
  - Write-through bypass: if RegWrite and WriteRegister==ReadRegisterN and the index is nonzero, ReadDataN = WriteData in the same cycle. Otherwise ReadDataN = reg[ReadRegisterN].
- Scoreboard clear:
  - at posedge, RegWrite with nonzero WriteRegister clears pending[WriteRegister].
  - A writeback to a register that is not pending is legal and leaves the bit at 0.
- Scoreboard set:
  - at posedge, Issue and !Stall and IssueRegister!=0 sets pending[IssueRegister].
  - Issue while Stall=1 is ignored.
- Simultaneous set and clear of the same index in one cycle: set wins, so the bit ends at 1 (new producer supersedes).
- Effective pending (combinational): effN = pending[N] and not (RegWrite and WriteRegister==N). A register whose writeback lands this cycle is not a hazard, because the bypass supplies its data.
- Stall = (ReadUse1 and eff[ReadRegister1]) or (ReadUse2 and eff[ReadRegister2]) or (Issue and eff[IssueRegister]).
  - The last term is a WAW hold: at most one outstanding producer per register.
  - Index 0 never contributes to Stall.
- PendingCount: registered popcount of pending. It updates the cycle after set/clear and never exceeds 31.

Decomposition:
- Shared package: REG_ZERO=5'd0, DATA_W/ADDR_W defaults, NUM_REGS=32.
- One natural sub-module: regfile_scoreboard_bits. It holds the pending vector, set/clear/priority logic and popcount, and outputs pending and PendingCount.
- Storage and bypass stay in the top module.

Test Plan:
- Reset, then read all 32 indices -> every ReadData=0, Stall=0, PendingCount=0. Assert reset mid-run with pending=0x0000_0104 -> all outputs return to 0 immediately.
- RegWrite reg 8 = 0xDEADBEEF with ReadRegister1=8 in the same cycle -> ReadData1=0xDEADBEEF that cycle (bypass), and still 0xDEADBEEF next cycle from storage. RegWrite reg 0 = 0x1234 -> ReadData of reg 0 stays 0.
- Issue reg 9. Next cycle ReadRegister2=9 with ReadUse2=1 -> Stall=1, PendingCount=1. In the cycle RegWrite reg 9 = 0x55 arrives -> Stall=0 and ReadData2=0x55. The following cycle PendingCount=0.
- Issue reg 10 while reg 10 is pending -> Stall=1 and the bit is unchanged. Issue reg 11 in a cycle where Stall=1 due to rs -> reg 11 is not set.
- Same cycle: RegWrite reg 12 (pending) plus Issue reg 12 with no other hazard -> Stall=0, and pending[12]=1 afterwards (set wins).
- ReadRegister1=5 pending with ReadUse1=0 -> Stall=0. Issue reg 0 -> no bit set, PendingCount unchanged.
